// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and the memory-responder state type.
package riscv_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned ILEN              = 32;
    localparam int unsigned MEM_DEPTH_DEFAULT = 1024;

    typedef enum logic {
        MEM_CLEAR,
        MEM_READY
    } mem_state_t;

endpackage

// File: rtl/riscv_mem_err_tracker.sv
// Sticky misaligned/out-of-range flags plus a saturating per-cycle error-event counter.
module riscv_mem_err_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_mis_evt,
    input  logic       i_rng_evt,
    input  logic       i_clr,
    output logic       o_err_misaligned,
    output logic       o_err_range,
    output logic [7:0] o_err_count
);

    logic       r_mis;
    logic       r_rng;
    logic [7:0] r_cnt;
    logic       w_any;

    assign w_any = i_mis_evt | i_rng_evt;

    // A clear and a new event in the same cycle leave the new event recorded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mis <= 1'b0;
            r_rng <= 1'b0;
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_mis <= i_mis_evt;
            r_rng <= i_rng_evt;
            r_cnt <= w_any ? 8'd1 : 8'd0;
        end else begin
            r_mis <= r_mis | i_mis_evt;
            r_rng <= r_rng | i_rng_evt;
            if (w_any && r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign o_err_misaligned = r_mis;
    assign o_err_range      = r_rng;
    assign o_err_count      = r_cnt;

endmodule

// File: rtl/riscv_mem_responder.sv
// Shared instruction/data word memory with zero-fill after reset, 1-cycle registered reads,
// write-first forwarding and misaligned/out-of-range error tracking.
module riscv_mem_responder #(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned ILEN  = riscv_pkg::ILEN,
    parameter int unsigned DEPTH = riscv_pkg::MEM_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] imem_addr,
    output logic [ILEN-1:0] imem_data,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_we,
    output logic [XLEN-1:0] dmem_rdata,
    output logic            ready,
    output logic            err_misaligned,
    output logic            err_range,
    output logic [7:0]      err_count,
    input  logic            err_clr
);

    import riscv_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    logic [XLEN-1:0] r_mem [DEPTH];
    mem_state_t      r_state;
    logic [AW-1:0]   r_clr_ptr;
    logic [ILEN-1:0] r_imem_data;
    logic [XLEN-1:0] r_dmem_rdata;

    logic [AW-1:0]   w_imem_idx;
    logic [AW-1:0]   w_dmem_idx;
    logic            w_imem_oor;
    logic            w_dmem_oor;
    logic            w_imem_mis;
    logic            w_dmem_mis;
    logic            w_active;
    logic            w_wr_en;
    logic            w_mis_evt;
    logic            w_rng_evt;
    logic [XLEN-1:0] w_imem_word;
    logic [XLEN-1:0] w_dmem_word;

    assign w_imem_idx = imem_addr[AW+1:2];
    assign w_dmem_idx = dmem_addr[AW+1:2];
    assign w_imem_oor = (imem_addr >> (AW + 2)) != '0;
    assign w_dmem_oor = (dmem_addr >> (AW + 2)) != '0;
    assign w_imem_mis = imem_addr[1:0] != 2'b00;
    assign w_dmem_mis = dmem_addr[1:0] != 2'b00;

    assign w_active  = (r_state == MEM_READY);
    assign w_wr_en   = w_active & dmem_we & ~w_dmem_oor & ~w_dmem_mis;
    // Data-port alignment only matters for stores; misaligned loads use the truncated index.
    assign w_mis_evt = w_active & (w_imem_mis | (dmem_we & w_dmem_mis));
    assign w_rng_evt = w_active & (w_imem_oor | w_dmem_oor);

    always_comb begin
        w_imem_word = '0;
        w_dmem_word = '0;
        if (!w_imem_oor) begin
            w_imem_word = (w_wr_en && w_dmem_idx == w_imem_idx) ? dmem_wdata : r_mem[w_imem_idx];
        end
        if (!w_dmem_oor) begin
            w_dmem_word = w_wr_en ? dmem_wdata : r_mem[w_dmem_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == MEM_CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_en) begin
            r_mem[w_dmem_idx] <= dmem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= MEM_CLEAR;
            r_clr_ptr    <= '0;
            r_imem_data  <= '0;
            r_dmem_rdata <= '0;
        end else begin
            case (r_state)
                MEM_CLEAR: begin
                    r_clr_ptr    <= r_clr_ptr + 1'b1;
                    r_imem_data  <= '0;
                    r_dmem_rdata <= '0;
                    if (&r_clr_ptr) begin
                        r_state <= MEM_READY;
                    end
                end
                MEM_READY: begin
                    r_imem_data  <= w_imem_word;
                    r_dmem_rdata <= w_dmem_word;
                end
                default: r_state <= MEM_CLEAR;
            endcase
        end
    end

    assign imem_data  = r_imem_data;
    assign dmem_rdata = r_dmem_rdata;
    assign ready      = (r_state == MEM_READY);

    riscv_mem_err_tracker u_err_tracker (
        .clk              (clk),
        .rst              (rst),
        .i_mis_evt        (w_mis_evt),
        .i_rng_evt        (w_rng_evt),
        .i_clr            (err_clr),
        .o_err_misaligned (err_misaligned),
        .o_err_range      (err_range),
        .o_err_count      (err_count)
    );

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench for riscv_mem_responder: vector table with scoreboard plus reset/saturation sequences.
module tb_riscv_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;
    logic        ready;
    logic        err_misaligned;
    logic        err_range;
    logic [7:0]  err_count;
    logic        err_clr;

    riscv_mem_responder dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_we        (dmem_we),
        .dmem_rdata     (dmem_rdata),
        .ready          (ready),
        .err_misaligned (err_misaligned),
        .err_range      (err_range),
        .err_count      (err_count),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        logic        we;
        logic        clr;
        logic [31:0] e_i;
        logic [31:0] e_d;
        logic        e_mis;
        logic        e_rng;
        logic [7:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] i;
        logic [31:0] d;
        logic        mis;
        logic        rng;
        logic [7:0]  cnt;
    } exp_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];
    exp_t sb [$];
    int errors  = 0;
    int checks  = 0;
    int bad_clr = 0;

    function automatic vec_t mk(input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] wd, input logic we, input logic clr,
                                input logic [31:0] e_i, input logic [31:0] e_d,
                                input logic e_mis, input logic e_rng, input logic [7:0] e_cnt);
        vec_t v;
        v.ia = ia; v.da = da; v.wd = wd; v.we = we; v.clr = clr;
        v.e_i = e_i; v.e_d = e_d; v.e_mis = e_mis; v.e_rng = e_rng; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready; outputs must stay zero while clearing.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
            if (!ready && (imem_data !== 32'd0 || dmem_rdata !== 32'd0 || err_count !== 8'd0))
                bad_clr++;
        end while (ready !== 1'b1 && n < 2000);
    endtask

    task automatic drive(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                         input logic we, input logic clr);
        imem_addr  = ia;
        dmem_addr  = da;
        dmem_wdata = wd;
        dmem_we    = we;
        err_clr    = clr;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        exp_t e;

        vecs[0]  = mk(32'h40,   32'h40,   32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[1]  = mk(32'h0,    32'h10,   32'hDEADBEEF, 1, 0, 32'h0,        32'hDEADBEEF, 0, 0, 0);
        vecs[2]  = mk(32'h10,   32'h10,   32'h0,        0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        vecs[3]  = mk(32'h20,   32'h20,   32'h12345678, 1, 0, 32'h12345678, 32'h12345678, 0, 0, 0);
        vecs[4]  = mk(32'h10,   32'h20,   32'h0,        0, 0, 32'hDEADBEEF, 32'h12345678, 0, 0, 0);
        vecs[5]  = mk(32'h0,    32'h11,   32'hCAFEF00D, 1, 0, 32'h0,        32'hDEADBEEF, 1, 0, 1);
        vecs[6]  = mk(32'h20,   32'h12,   32'h0,        0, 0, 32'h12345678, 32'hDEADBEEF, 1, 0, 1);
        vecs[7]  = mk(32'h0,    32'h0,    32'h0,        0, 1, 32'h0,        32'h0,        0, 0, 0);
        vecs[8]  = mk(32'h0,    32'h1000, 32'hAAAA5555, 1, 0, 32'h0,        32'h0,        0, 1, 1);
        vecs[9]  = mk(32'h1000, 32'h1000, 32'h0,        0, 0, 32'h0,        32'h0,        0, 1, 2);
        vecs[10] = mk(32'hFFC,  32'hFFC,  32'h0BADCAFE, 1, 0, 32'h0BADCAFE, 32'h0BADCAFE, 0, 1, 2);
        vecs[11] = mk(32'h12,   32'h20,   32'h0,        0, 1, 32'hDEADBEEF, 32'h12345678, 1, 0, 1);
        vecs[12] = mk(32'h0,    32'h0,    32'h0,        0, 0, 32'h0,        32'h0,        1, 0, 1);

        // Reset while clearing; stores and bad addresses must be ignored until ready.
        rst = 1'b1;
        drive(32'h1002, 32'h40, 32'hFFFFFFFF, 1, 0);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_imem", imem_data, 0);
        chk("rst_dmem", dmem_rdata, 0);
        chk("rst_mis", err_misaligned, 0);
        chk("rst_rng", err_range, 0);
        chk("rst_cnt", err_count, 0);
        repeat (3) tick();
        rst = 1'b0;
        wait_ready(n);
        chk("ready_latency", n, 1024);
        chk("clear_outputs_zero", bad_clr, 0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].ia, vecs[i].da, vecs[i].wd, vecs[i].we, vecs[i].clr);
            sb.push_back('{i: vecs[i].e_i, d: vecs[i].e_d, mis: vecs[i].e_mis,
                           rng: vecs[i].e_rng, cnt: vecs[i].e_cnt});
            tick();
            e = sb.pop_front();
            chk($sformatf("v%0d_imem", i), imem_data, e.i);
            chk($sformatf("v%0d_dmem", i), dmem_rdata, e.d);
            chk($sformatf("v%0d_mis", i), err_misaligned, e.mis);
            chk($sformatf("v%0d_rng", i), err_range, e.rng);
            chk($sformatf("v%0d_cnt", i), err_count, e.cnt);
        end

        // Continuous misaligned fetch: count climbs one per cycle and saturates.
        drive(32'h2, 32'h0, 32'h0, 0, 0);
        repeat (100) tick();
        chk("sat_cnt_101", err_count, 101);
        repeat (200) tick();
        chk("sat_cnt_255", err_count, 255);
        chk("sat_mis", err_misaligned, 1);
        drive(32'h0, 32'h0, 32'h0, 0, 1);
        tick();
        err_clr = 1'b0;
        chk("clr_cnt", err_count, 0);
        chk("clr_mis", err_misaligned, 0);
        chk("clr_rng", err_range, 0);

        // Mid-operation async reset, then a second reset 500 cycles into the fill.
        drive(32'h0, 32'h40, 32'h00000077, 1, 0);
        tick();
        drive(32'h2, 32'h40, 32'h0, 0, 0);
        tick();
        chk("pre_rst_dmem", dmem_rdata, 32'h77);
        chk("pre_rst_cnt", err_count, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_dmem", dmem_rdata, 0);
        chk("async_rst_cnt", err_count, 0);
        chk("async_rst_ready", ready, 0);
        tick();
        rst = 1'b0;
        drive(32'h1002, 32'h40, 32'hFFFFFFFF, 1, 0);
        repeat (500) tick();
        chk("mid_fill_ready", ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bad_clr = 0;
        wait_ready(n);
        chk("refill_latency", n, 1024);
        chk("refill_outputs_zero", bad_clr, 0);
        drive(32'h10, 32'h20, 32'h0, 0, 0);
        tick();
        chk("refill_imem_0x10", imem_data, 0);
        chk("refill_dmem_0x20", dmem_rdata, 0);
        drive(32'h40, 32'hFFC, 32'h0, 0, 0);
        tick();
        chk("refill_imem_0x40", imem_data, 0);
        chk("refill_dmem_0xffc", dmem_rdata, 0);
        chk("refill_cnt", err_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
